// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter - round-robin CPU/host arbiter for the single-port data RAM
// Revision: 1.0
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_host
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [1:0] state;
  logic [3:0] count;
  logic       we_q;
  logic       pick_host;

  // On a tie the requester that did not win last time is served.
  assign pick_host = host_req & (~cpu_req | ~grant_host);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdata      <= '0;
      grant_host <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | host_req) begin
            grant_host <= pick_host;
            we_q       <= pick_host ? host_we    : cpu_we;
            ram_addr   <= pick_host ? host_addr  : cpu_addr;
            ram_wdata  <= pick_host ? host_wdata : cpu_wdata;
            count      <= CNT_LOAD;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            if (!we_q) begin
              rdata <= ram_rdata;
            end
            state <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The counter still holds its load value only in the first access cycle.
  assign ram_en    = (state == ACCESS);
  assign ram_we    = ram_en & we_q & (count == CNT_LOAD);
  assign cpu_ack   = (state == DONE) & ~grant_host;
  assign host_ack  = (state == DONE) &  grant_host;
  assign busy      = (state != IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a
// transaction-schedule model; a second LAT=1 instance covers the short-latency build.
module tb_data_mem_arbiter;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [7:0]  cpu_addr, host_addr;
  logic [63:0] cpu_wdata, host_wdata;
  logic        cpu_ack, cpu_stall, host_ack, ram_en, ram_we, busy, grant_host;
  logic [63:0] rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;

  logic        l1_cpu_req, l1_cpu_we, l1_host_req, l1_host_we;
  logic [7:0]  l1_cpu_addr, l1_host_addr;
  logic [63:0] l1_cpu_wdata, l1_host_wdata;
  logic        l1_cpu_ack, l1_cpu_stall, l1_host_ack, l1_ram_en, l1_ram_we, l1_busy, l1_grant_host;
  logic [63:0] l1_rdata, l1_ram_wdata, l1_ram_rdata;
  logic [7:0]  l1_ram_addr;

  logic [63:0] ram     [0:255];
  logic [63:0] ram1    [0:255];
  logic [63:0] ref_mem [0:255];

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(64), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .grant_host(grant_host)
  );

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(64), .LAT(1)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(l1_cpu_req), .cpu_we(l1_cpu_we), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_cpu_wdata),
    .cpu_ack(l1_cpu_ack), .cpu_stall(l1_cpu_stall),
    .host_req(l1_host_req), .host_we(l1_host_we), .host_addr(l1_host_addr),
    .host_wdata(l1_host_wdata), .host_ack(l1_host_ack), .rdata(l1_rdata),
    .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr), .ram_wdata(l1_ram_wdata),
    .ram_rdata(l1_ram_rdata), .busy(l1_busy), .grant_host(l1_grant_host)
  );

  // Behavioural RAMs: asynchronous read, write on the clock edge.
  assign ram_rdata    = ram[ram_addr];
  assign l1_ram_rdata = ram1[l1_ram_addr];
  always @(posedge clock) begin
    if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
    if (l1_ram_en && l1_ram_we) ram1[l1_ram_addr] <= l1_ram_wdata;
  end

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Transaction schedule model: edge index of the last grant, what was granted,
  // and the earliest edge at which the next request may be sampled.
  int          n = 0;
  int          free_edge = 0;
  int          g_edge = 0;
  bit          act = 0;
  bit          last_host = 1;
  bit          owner_host = 0;
  bit          own_we = 0;
  logic [7:0]  own_addr = 0;
  logic [63:0] own_wdata = 0;
  logic [63:0] exp_rd = 0;
  logic [63:0] exp_rdata = 0;
  logic [7:0]  exp_addr = 0;
  logic [63:0] exp_wdata = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    act = 0; last_host = 1; free_edge = 0;
    exp_rdata = 0; exp_addr = 0; exp_wdata = 0;
  endtask

  task automatic check_outputs();
    int k;
    bit in_acc, in_done, e_cack, e_hack;
    k       = n - g_edge;
    in_acc  = act && k >= 0 && k < LAT;
    in_done = act && k == LAT;
    e_cack  = in_done && !owner_host;
    e_hack  = in_done && owner_host;
    if (in_done && !own_we) exp_rdata = exp_rd;
    chk("ram_en",     {63'd0, ram_en},     {63'd0, in_acc});
    chk("ram_we",     {63'd0, ram_we},     {63'd0, in_acc && k == 0 && own_we});
    chk("busy",       {63'd0, busy},       {63'd0, in_acc || in_done});
    chk("cpu_ack",    {63'd0, cpu_ack},    {63'd0, e_cack});
    chk("host_ack",   {63'd0, host_ack},   {63'd0, e_hack});
    chk("cpu_stall",  {63'd0, cpu_stall},  {63'd0, cpu_req && !e_cack});
    chk("grant_host", {63'd0, grant_host}, {63'd0, last_host});
    chk("ram_addr",   {56'd0, ram_addr},   {56'd0, exp_addr});
    chk("ram_wdata",  ram_wdata,           exp_wdata);
    chk("rdata",      rdata,               exp_rdata);
  endtask

  task automatic tick();
    @(posedge clock);
    n++;
    if (!reset && n >= free_edge && (cpu_req || host_req)) begin
      owner_host = (cpu_req && host_req) ? !last_host : host_req;
      last_host  = owner_host;
      act        = 1;
      g_edge     = n;
      own_we     = owner_host ? host_we    : cpu_we;
      own_addr   = owner_host ? host_addr  : cpu_addr;
      own_wdata  = owner_host ? host_wdata : cpu_wdata;
      exp_addr   = own_addr;
      exp_wdata  = own_wdata;
      if (own_we) ref_mem[own_addr] = own_wdata;
      else        exp_rd = ref_mem[own_addr];
      free_edge  = n + LAT + 2;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic wait_ack(input bit host, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(host ? host_ack : cpu_ack) && cycles < 20);
    chk("ack_seen", {63'd0, (host ? host_ack : cpu_ack)}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_clear();
    check_outputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic new_cpu_req();
    cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 31));
    cpu_wdata = {$urandom, $urandom};
  endtask

  task automatic new_host_req();
    host_req = 1; host_we = 1'($urandom_range(0, 1)); host_addr = 8'($urandom_range(0, 31));
    host_wdata = {$urandom, $urandom};
  endtask

  initial begin
    int c;
    int q_order[$];
    int cpu_t[$];
    int host_t[$];
    logic [63:0] v;

    clock = 0; reset = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    l1_cpu_req = 0; l1_cpu_we = 0; l1_cpu_addr = 0; l1_cpu_wdata = 0;
    l1_host_req = 0; l1_host_we = 0; l1_host_addr = 0; l1_host_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      ram[i] = v; ref_mem[i] = v; ram1[i] = ~v;
    end
    ram[8'h10] = 64'h0123_4567_89AB_CDEF; ref_mem[8'h10] = 64'h0123_4567_89AB_CDEF;

    // Reset state, then single CPU load.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    wait_ack(0, c);
    chk("load_latency", 64'(c), 64'(LAT + 1));
    chk("load_data", rdata, 64'h0123_4567_89AB_CDEF);
    chk("load_stall_in_ack", {63'd0, cpu_stall}, 64'd0);
    cpu_req = 0;
    tick();

    // Host store then CPU readback.
    host_req = 1; host_we = 1; host_addr = 8'h05; host_wdata = 64'hDEAD_BEEF;
    tick();
    chk("store_strobe", {63'd0, ram_we}, 64'd1);
    chk("store_addr", {56'd0, ram_addr}, 64'h05);
    wait_ack(1, c);
    chk("store_latency", 64'(c + 1), 64'(LAT + 1));
    host_req = 0;
    tick();
    chk("store_ram", ram[8'h05], 64'hDEAD_BEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    wait_ack(0, c);
    chk("readback", rdata, 64'hDEAD_BEEF);
    cpu_req = 0;
    tick();

    // Simultaneous requests after reset alternate CPU, host, CPU.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    host_req = 1; host_we = 0; host_addr = 8'h05;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (cpu_ack) q_order.push_back(0);
      if (host_ack) q_order.push_back(1);
      chk("ack_overlap", {63'd0, cpu_ack & host_ack}, 64'd0);
    end
    chk("rr_count", 64'(q_order.size()), 64'd3);
    if (q_order.size() == 3) begin
      chk("rr_first", 64'(q_order[0]), 64'd0);
      chk("rr_second", 64'(q_order[1]), 64'd1);
      chk("rr_third", 64'(q_order[2]), 64'd0);
    end
    cpu_req = 0; host_req = 0;
    tick();

    // CPU back-to-back; host raised mid-access is served next.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (cpu_ack) cpu_t.push_back(t);
      if (host_ack) host_t.push_back(t);
      if (t == 9) begin host_req = 1; host_we = 0; host_addr = 8'h05; end
    end
    cpu_req = 0; host_req = 0;
    chk("b2b_count", 64'(cpu_t.size()), 64'd3);
    if (cpu_t.size() >= 2) chk("b2b_spacing", 64'(cpu_t[1] - cpu_t[0]), 64'(LAT + 2));
    chk("host_next_count", 64'(host_t.size()), 64'd1);
    if (host_t.size() == 1) chk("host_next_time", 64'(host_t[0]), 64'd15);
    tick();

    // Reset in the second access cycle abandons the access.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    tick();
    tick();
    chk("pre_reset_en", {63'd0, ram_en}, 64'd1);
    do_reset();
    chk("reset_stall", {63'd0, cpu_stall}, 64'd1);
    wait_ack(0, c);
    chk("restart_latency", 64'(c), 64'(LAT + 1));
    chk("restart_data", rdata, 64'h0123_4567_89AB_CDEF);
    cpu_req = 0;
    tick();

    // LAT=1 instance: load then store.
    ram1[8'h22] = 64'hCAFE_F00D_1234_5678;
    l1_cpu_req = 1; l1_cpu_we = 0; l1_cpu_addr = 8'h22;
    tick();
    chk("l1_en", {63'd0, l1_ram_en}, 64'd1);
    chk("l1_ack_early", {63'd0, l1_cpu_ack}, 64'd0);
    tick();
    chk("l1_ack", {63'd0, l1_cpu_ack}, 64'd1);
    chk("l1_data", l1_rdata, 64'hCAFE_F00D_1234_5678);
    chk("l1_en_done", {63'd0, l1_ram_en}, 64'd0);
    l1_cpu_req = 0;
    tick();
    chk("l1_ack_clear", {63'd0, l1_cpu_ack}, 64'd0);
    l1_host_req = 1; l1_host_we = 1; l1_host_addr = 8'h33; l1_host_wdata = 64'h5555_AAAA_0F0F_F0F0;
    tick();
    chk("l1_we", {63'd0, l1_ram_we}, 64'd1);
    tick();
    chk("l1_we_one", {63'd0, l1_ram_we}, 64'd0);
    chk("l1_host_ack", {63'd0, l1_host_ack}, 64'd1);
    chk("l1_ram", ram1[8'h33], 64'h5555_AAAA_0F0F_F0F0);
    chk("l1_rdata_kept", l1_rdata, 64'hCAFE_F00D_1234_5678);
    l1_host_req = 0;
    tick();

    // Random traffic, including kept-high requests and abandoned ones.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cpu_req) begin
        if (cpu_ack) begin
          if ($urandom_range(0, 1) == 1) new_cpu_req(); else cpu_req = 0;
        end else if ($urandom_range(0, 39) == 0) cpu_req = 0;
      end else if ($urandom_range(0, 2) == 0) new_cpu_req();
      if (host_req) begin
        if (host_ack) begin
          if ($urandom_range(0, 1) == 1) new_host_req(); else host_req = 0;
        end else if ($urandom_range(0, 39) == 0) host_req = 0;
      end else if ($urandom_range(0, 2) == 0) new_host_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
